reg_bank_4x16: RTL and testbench

//  Four-entry 16-bit register bank that produces reg0..reg3 for the downstream 4:1 source selector.
//  It has two write sources:
//   - ALU write-back, through a one-stage staging register.
//   - External load port with a valid/ready handshake.
//  A sequencer clears all four registers, one per cycle, on request.
//  Per-register dirty flags report which registers hold written data.

---
 rtl/reg_bank_4x16_if.sv | 36 +++
 rtl/reg_bank_4x16.sv | 93 +++++++++
 tb/tb_reg_bank_4x16.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_4x16_if.sv
// Bus bundle for the 4x16 register bank.
// Master drives requests; slave returns state.
interface reg_bank_4x16_if #(
  parameter int nrOfBits = 16
);
  logic                wb_en;
  logic [1:0]          wb_sel;
  logic [nrOfBits-1:0] wb_data;
  logic                ld_valid;
  logic [1:0]          ld_sel;
  logic [nrOfBits-1:0] ld_data;
  logic                ld_ready;
  logic                clr_start;
  logic                busy;
  logic [nrOfBits-1:0] reg0;
  logic [nrOfBits-1:0] reg1;
  logic [nrOfBits-1:0] reg2;
  logic [nrOfBits-1:0] reg3;
  logic [3:0]          dirty;

  modport master (
    output wb_en, wb_sel, wb_data,
    output ld_valid, ld_sel, ld_data,
    output clr_start,
    input  ld_ready, busy,
    input  reg0, reg1, reg2, reg3, dirty
  );

  modport slave (
    input  wb_en, wb_sel, wb_data,
    input  ld_valid, ld_sel, ld_data,
    input  clr_start,
    output ld_ready, busy,
    output reg0, reg1, reg2, reg3, dirty
  );
endinterface

// File: rtl/reg_bank_4x16.sv
// Four-entry register bank: staged ALU write-back,
// handshaked load port and a one-per-cycle clear sweep.
module reg_bank_4x16 #(
  parameter int nrOfBits = 16
) (
  input logic [4:0]      logisimClockTree0,
  input logic            reset,
  reg_bank_4x16_if.slave bus
);

  typedef enum logic {
    IDLE,
    CLR
  } state_t;

  logic                clk;
  logic [3:0]          unusedClkBits;
  state_t              state;
  logic [1:0]          idx;
  logic                busyQ;
  logic                pv;
  logic [1:0]          ps;
  logic [nrOfBits-1:0] pd;
  logic [nrOfBits-1:0] regs [4];
  logic [3:0]          dirtyQ;
  logic                wbTake;
  logic                ldAccept;

  assign clk           = logisimClockTree0[4];
  assign unusedClkBits = logisimClockTree0[3:0];

  // A load to the staged target waits so it lands last.
  assign bus.ld_ready = !reset && !busyQ &&
                        !(pv && (ps == bus.ld_sel));
  assign ldAccept     = bus.ld_valid && bus.ld_ready;
  assign wbTake       = bus.wb_en && !busyQ;

  assign bus.busy  = busyQ;
  assign bus.reg0  = regs[0];
  assign bus.reg1  = regs[1];
  assign bus.reg2  = regs[2];
  assign bus.reg3  = regs[3];
  assign bus.dirty = dirtyQ;

  // Staging, commits, loads and clear sweep; later writes win.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
      dirtyQ <= '0;
      pv     <= 1'b0;
      ps     <= '0;
      pd     <= '0;
      state  <= IDLE;
      idx    <= '0;
      busyQ  <= 1'b0;
    end else begin
      if (pv) begin
        regs[ps]   <= pd;
        dirtyQ[ps] <= 1'b1;
      end
      if (ldAccept) begin
        regs[bus.ld_sel]   <= bus.ld_data;
        dirtyQ[bus.ld_sel] <= 1'b1;
      end
      pv <= wbTake;
      if (wbTake) begin
        ps <= bus.wb_sel;
        pd <= bus.wb_data;
      end
      unique case (state)
        IDLE: begin
          if (bus.clr_start) begin
            state <= CLR;
            idx   <= '0;
            busyQ <= 1'b1;
          end
        end
        CLR: begin
          regs[idx]   <= '0;
          dirtyQ[idx] <= 1'b0;
          idx         <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= IDLE;
            busyQ <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_4x16.sv
// Bench for reg_bank_4x16: vector table, corner
// sequences and random traffic against a model.
module tb_reg_bank_4x16;

  typedef struct {
    bit          rst;
    bit          wbEn;
    logic [1:0]  wbSel;
    logic [15:0] wbData;
    bit          ldValid;
    logic [1:0]  ldSel;
    logic [15:0] ldData;
    bit          clrStart;
    bit          expReady;
    logic [63:0] expRegs;
    logic [3:0]  expDirty;
    bit          expBusy;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
  } wb_t;

  logic       clk;
  logic       rst;
  logic [4:0] clkTree;
  int         errors;
  int         checks;

  logic [15:0] mReg [4];
  logic [3:0]  mDirty;
  int          clrLeft;
  wb_t         pend [$];

  vec_t tbl [10];

  reg_bank_4x16_if bus ();

  assign clkTree = {clk, 4'b0000};

  reg_bank_4x16 dut (
    .logisimClockTree0(clkTree),
    .reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    bit rs, bit we, logic [1:0] ws, logic [15:0] wd,
    bit lv, logic [1:0] ls, logic [15:0] ld, bit cs,
    bit er, logic [63:0] eg, logic [3:0] ed, bit eb);
    vec_t v;
    v.rst = rs; v.wbEn = we; v.wbSel = ws; v.wbData = wd;
    v.ldValid = lv; v.ldSel = ls; v.ldData = ld;
    v.clrStart = cs; v.expReady = er; v.expRegs = eg;
    v.expDirty = ed; v.expBusy = eb;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dutReg(int i);
    case (i)
      0:       return bus.reg0;
      1:       return bus.reg1;
      2:       return bus.reg2;
      default: return bus.reg3;
    endcase
  endfunction

  function automatic bit modelReady();
    if (rst || clrLeft != 0) return 1'b0;
    if (pend.size() > 0 && pend[0].sel == bus.ld_sel)
      return 1'b0;
    return 1'b1;
  endfunction

  // Reference: pending write-backs land one edge later,
  // loads land on accept, a sweep zeroes one index per edge.
  task automatic modelEdge();
    bit  rdy;
    bit  wasIdle;
    wb_t w;
    int  r;
    rdy     = modelReady();
    wasIdle = (clrLeft == 0);
    if (rst) begin
      for (int i = 0; i < 4; i++) mReg[i] = 16'h0;
      mDirty  = 4'h0;
      clrLeft = 0;
      pend.delete();
    end else begin
      if (pend.size() > 0) begin
        w = pend.pop_front();
        mReg[w.sel]   = w.data;
        mDirty[w.sel] = 1'b1;
      end
      if (bus.ld_valid && rdy) begin
        mReg[bus.ld_sel]   = bus.ld_data;
        mDirty[bus.ld_sel] = 1'b1;
      end
      if (clrLeft > 0) begin
        r = 4 - clrLeft;
        mReg[r]   = 16'h0;
        mDirty[r] = 1'b0;
        clrLeft--;
      end else if (bus.clr_start) begin
        clrLeft = 4;
      end
      if (bus.wb_en && wasIdle) begin
        w.sel  = bus.wb_sel;
        w.data = bus.wb_data;
        pend.push_back(w);
      end
    end
  endtask

  task automatic edgeStep();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic checkState();
    for (int i = 0; i < 4; i++)
      chk($sformatf("reg%0d", i), 64'(dutReg(i)), 64'(mReg[i]));
    chk("dirty", 64'(bus.dirty), 64'(mDirty));
    chk("busy", 64'(bus.busy), 64'(clrLeft > 0));
  endtask

  task automatic cycle();
    #1;
    chk("ld_ready", 64'(bus.ld_ready), 64'(modelReady()));
    edgeStep();
    checkState();
  endtask

  task automatic idle();
    rst = 1'b0;
    bus.wb_en = 1'b0; bus.wb_sel = 2'd0; bus.wb_data = 16'h0;
    bus.ld_valid = 1'b0; bus.ld_sel = 2'd0; bus.ld_data = 16'h0;
    bus.clr_start = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    clrLeft = 0;
    mDirty  = 4'h0;
    for (int i = 0; i < 4; i++) mReg[i] = 16'h0;
    idle();
    rst = 1'b1;

    tbl[0] = mk(1, 0, 0, 16'h0, 0, 0, 16'h0, 0,
                0, 64'h0, 4'b0000, 0);
    tbl[1] = mk(0, 0, 0, 16'h0, 0, 0, 16'h0, 0,
                1, 64'h0, 4'b0000, 0);
    tbl[2] = mk(0, 1, 2, 16'h1234, 0, 0, 16'h0, 0,
                1, 64'h0, 4'b0000, 0);
    tbl[3] = mk(0, 0, 0, 16'h0, 0, 0, 16'h0, 0,
                1, 64'h0000_1234_0000_0000, 4'b0100, 0);
    tbl[4] = mk(0, 1, 0, 16'h5555, 0, 0, 16'h0, 0,
                1, 64'h0000_1234_0000_0000, 4'b0100, 0);
    tbl[5] = mk(0, 0, 0, 16'h0, 1, 1, 16'hBEEF, 0,
                1, 64'h0000_1234_BEEF_5555, 4'b0111, 0);
    tbl[6] = mk(0, 1, 3, 16'h1111, 0, 0, 16'h0, 0,
                1, 64'h0000_1234_BEEF_5555, 4'b0111, 0);
    tbl[7] = mk(0, 0, 0, 16'h0, 1, 3, 16'h2222, 0,
                0, 64'h1111_1234_BEEF_5555, 4'b1111, 0);
    tbl[8] = mk(0, 0, 0, 16'h0, 1, 3, 16'h2222, 0,
                1, 64'h2222_1234_BEEF_5555, 4'b1111, 0);
    tbl[9] = mk(1, 0, 0, 16'h0, 1, 0, 16'hFFFF, 0,
                0, 64'h0, 4'b0000, 0);

    for (int i = 0; i < 10; i++) begin
      rst           = tbl[i].rst;
      bus.wb_en     = tbl[i].wbEn;
      bus.wb_sel    = tbl[i].wbSel;
      bus.wb_data   = tbl[i].wbData;
      bus.ld_valid  = tbl[i].ldValid;
      bus.ld_sel    = tbl[i].ldSel;
      bus.ld_data   = tbl[i].ldData;
      bus.clr_start = tbl[i].clrStart;
      #1;
      chk($sformatf("v%0d ld_ready", i),
          64'(bus.ld_ready), 64'(tbl[i].expReady));
      edgeStep();
      chk($sformatf("v%0d regs", i),
          {bus.reg3, bus.reg2, bus.reg1, bus.reg0},
          tbl[i].expRegs);
      chk($sformatf("v%0d dirty", i),
          64'(bus.dirty), 64'(tbl[i].expDirty));
      chk($sformatf("v%0d busy", i),
          64'(bus.busy), 64'(tbl[i].expBusy));
    end

    // Preload then sweep; a second start mid-sweep is ignored.
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_sel   = 2'(i);
      bus.ld_data  = 16'hA5A5;
      cycle();
    end
    idle();
    bus.clr_start = 1'b1;
    cycle();
    chk("sweep busy start", 64'(bus.busy), 64'd1);
    chk("sweep reg0 held", 64'(bus.reg0), 64'hA5A5);
    for (int k = 1; k <= 4; k++) begin
      bus.clr_start = (k == 2);
      bus.ld_valid  = 1'b1;
      bus.ld_sel    = 2'(k);
      bus.ld_data   = 16'h7777;
      #1;
      chk("sweep ld_ready", 64'(bus.ld_ready), 64'd0);
      edgeStep();
      checkState();
      chk($sformatf("sweep reg%0d zero", k - 1),
          64'(dutReg(k - 1)), 64'h0);
      if (k < 4)
        chk($sformatf("sweep reg%0d kept", k),
            64'(dutReg(k)), 64'hA5A5);
      chk("sweep busy", 64'(bus.busy), 64'(k < 4));
    end
    idle();
    cycle();
    chk("sweep no restart", 64'(bus.busy), 64'd0);
    chk("sweep dirty", 64'(bus.dirty), 64'd0);

    // Staged commit vs clear on the same index: clear wins.
    bus.wb_en = 1'b1; bus.wb_sel = 2'd0; bus.wb_data = 16'h9999;
    bus.clr_start = 1'b1;
    cycle();
    idle();
    cycle();
    chk("clr beats commit", 64'(bus.reg0), 64'h0);
    chk("clr beats dirty", 64'(bus.dirty), 64'h0);
    repeat (4) cycle();

    // Staged commit to a later index lands, then is swept.
    bus.wb_en = 1'b1; bus.wb_sel = 2'd1; bus.wb_data = 16'h4444;
    bus.clr_start = 1'b1;
    cycle();
    idle();
    cycle();
    chk("commit mid sweep", 64'(bus.reg1), 64'h4444);
    chk("commit dirty", 64'(bus.dirty), 64'b0010);
    cycle();
    chk("commit swept", 64'(bus.reg1), 64'h0);
    repeat (3) cycle();

    // Reset mid-sweep.
    bus.ld_valid = 1'b1; bus.ld_sel = 2'd2; bus.ld_data = 16'h6666;
    cycle();
    idle();
    bus.clr_start = 1'b1;
    cycle();
    idle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst reg2", 64'(bus.reg2), 64'h0);
    chk("rst dirty", 64'(bus.dirty), 64'h0);
    idle();
    cycle();
    chk("rst idle", 64'(bus.busy), 64'd0);

    // Reset drops a staged write-back.
    bus.wb_en = 1'b1; bus.wb_sel = 2'd3; bus.wb_data = 16'hABCD;
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    idle();
    cycle();
    chk("rst drops staging", 64'(bus.reg3), 64'h0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 49) == 0);
      bus.wb_en     = (clrLeft == 0) && ($urandom_range(0, 1) == 1);
      bus.wb_sel    = 2'($urandom_range(0, 3));
      bus.wb_data   = 16'($urandom());
      bus.ld_valid  = ($urandom_range(0, 1) == 1);
      bus.ld_sel    = 2'($urandom_range(0, 3));
      bus.ld_data   = 16'($urandom());
      bus.clr_start = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
